// File: rtl/bound_flasher_monitor.sv
// bound_flasher_monitor: passive decoder/checker for the bound flasher LED bus; define BFM_KICK_COUNT_EN
// to build the saturating kickback counter, otherwise kick_count reads 0.
module bound_flasher_monitor #(
  parameter int KICK_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       led_in,
  input  logic              err_clr,
  output logic [2:0]        phase,
  output logic [4:0]        lit_count,
  output logic              cycle_done,
  output logic [KICK_W-1:0] kick_count,
  output logic              err,
  output logic [2:0]        err_code
);
  typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3, ERR} phase_t;
  phase_t st, st_n;
  logic [15:0] led_q;
  logic [4:0] cn, cp;
  logic [2:0] code;
  logic k2, k2_n, done_n, up, dn;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      led_q <= '0;
      k2 <= 1'b0;
      cycle_done <= 1'b0;
      err <= 1'b0;
      err_code <= 3'd0;
    end else begin
      st <= st_n;
      led_q <= led_in;
      k2 <= k2_n;
      cycle_done <= done_n;
      err <= code != 3'd0 || (err && !err_clr);
      err_code <= code != 3'd0 && (!err || err_clr) ? code : err_clr ? 3'd0 : err_code;
    end
  always_comb begin
    cn = 5'($countones(led_in));
    cp = 5'($countones(led_q));
    up = cn == cp + 5'd1;
    dn = cp == cn + 5'd1;
    st_n = st;
    k2_n = k2;
    done_n = 1'b0;
    code = 3'd0;
    if ((led_in & (led_in + 16'd1)) != 16'd0) code = 3'd1;
    else if (st == ERR) st_n = cn == 5'd0 ? IDLE : ERR;
    else if (!up && !dn) code = cn != cp ? 3'd2 : st == IDLE ? 3'd0 : 3'd3;
    else begin
      // each phase has a fixed direction; only the listed bounds may reverse it
      case (st)
        IDLE: st_n = UP1;
        UP1: if (dn && cp == 5'd6) st_n = DN1;
             else if (dn || cp >= 5'd6) code = 3'd4;
        DN1: if (up && cp == 5'd0) st_n = UP2;
             else if (up) code = 3'd4;
        UP2: if (dn && cp == 5'd6) st_n = DN1;
             else if (dn && cp == 5'd11) begin st_n = DN2; k2_n = 1'b0; end
             else if (dn || cp >= 5'd11) code = 3'd4;
        DN2: if (up && cp == 5'd6) st_n = UP3;
             else if (dn && cp == 5'd6 && k2) st_n = DN3;
             else if (up || cp <= 5'd6) code = 3'd4;
        UP3: if (dn && cp == 5'd11) begin st_n = DN2; k2_n = 1'b1; end
             else if (dn && cp == 5'd16) st_n = DN3;
             else if (dn) code = 3'd4;
        DN3: if (up) code = 3'd4;
             else if (cn == 5'd0) begin st_n = IDLE; done_n = 1'b1; end
        default: code = 3'd4;
      endcase
    end
    if (code != 3'd0) st_n = ERR;
  end
`ifdef BFM_KICK_COUNT_EN
  logic [KICK_W-1:0] kick_q;
  logic kick;
  assign kick = code == 3'd0 && cp == 5'd6 && ((st == UP2 && dn) || (st == DN2 && up && k2));
  always_ff @(posedge clk or posedge reset)
    if (reset) kick_q <= '0;
    else if (kick && !(&kick_q)) kick_q <= kick_q + KICK_W'(1);
`endif
  always_comb begin
    phase = st;
    lit_count = cp;
`ifdef BFM_KICK_COUNT_EN
    kick_count = kick_q;
`else
    kick_count = '0;
`endif
  end
endmodule
